// File: rtl/ysyx_23060332_lsu.sv
// Load/store unit: one outstanding bus access per request, load formatting and writeback pulse.
// Optional alignment checking is enabled by defining YSYX_23060332_LSU_MISALIGN_CHK_EN.
module ysyx_23060332_lsu #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          mem_ren,
    input  logic [AW-1:0] mem_raddr,
    input  logic          mem_wen,
    input  logic [AW-1:0] mem_waddr,
    input  logic [DW-1:0] mem_wdata,
    input  logic [7:0]    mem_wmask,
    input  logic [2:0]    ld_func3,
    output logic          in_ready,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    output logic [3:0]    bus_wstrb,
    input  logic          bus_ack,
    input  logic [DW-1:0] bus_rdata,
    output logic          out_valid,
    output logic [DW-1:0] out_rdata,
    output logic          out_err,
    output logic          lsu_busy
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t        state;
    state_t        next_state;

    logic          accept;
    logic [AW-1:0] req_addr;
    logic [1:0]    req_off;
    logic [3:0]    store_strb;
    logic [DW-1:0] store_data;
    logic          misalign;

    logic [1:0]    off_q;
    logic [2:0]    func3_q;
    logic          load_q;
    logic [DW-1:0] shifted;
    logic [DW-1:0] load_data;
    logic          err_q;

    logic          unused_wmask;
    assign unused_wmask = &{1'b0, mem_wmask[7:4]};

    // A write always wins when both enables are set; the read is dropped.
    assign accept     = in_valid & (mem_ren | mem_wen);
    assign req_addr   = mem_wen ? mem_waddr : mem_raddr;
    assign req_off    = req_addr[1:0];
    assign store_strb = mem_wmask[3:0] << req_off;
    assign store_data = mem_wdata << {req_off, 3'b000};

`ifdef YSYX_23060332_LSU_MISALIGN_CHK_EN
    always_comb begin
        misalign = 1'b0;
        if (mem_wen) begin
            if (mem_wmask[3])
                misalign = (req_off != 2'b00);
            else if (mem_wmask[1])
                misalign = req_off[0];
        end else begin
            case (ld_func3[1:0])
                2'b00:   misalign = 1'b0;
                2'b01:   misalign = req_off[0];
                default: misalign = (req_off != 2'b00);
            endcase
        end
    end
    assign out_err = err_q;
`else
    assign misalign = 1'b0;
    assign out_err  = 1'b0;
`endif

    // Format the captured word: align to byte lane 0, then extend by access size.
    assign shifted = bus_rdata >> {off_q, 3'b000};
    always_comb begin
        load_data = shifted;
        case (func3_q)
            3'b000:  load_data = {{(DW-8){shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{(DW-16){shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {{(DW-8){1'b0}}, shifted[7:0]};
            3'b101:  load_data = {{(DW-16){1'b0}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = misalign ? DONE : REQ;
            REQ:     if (bus_ack) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        bus_req   = 1'b0;
        out_valid = 1'b0;
        lsu_busy  = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            REQ:     begin bus_req = 1'b1; lsu_busy = 1'b1; end
            DONE:    begin out_valid = 1'b1; lsu_busy = 1'b1; end
            default: in_ready = 1'b1;
        endcase
    end

    // Bus fields stay frozen from accept through ack; result is captured on ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wstrb <= 4'b0000;
            off_q     <= 2'b00;
            func3_q   <= 3'b000;
            load_q    <= 1'b0;
            out_rdata <= '0;
            err_q     <= 1'b0;
        end else if (state == IDLE && accept) begin
            off_q   <= req_off;
            func3_q <= ld_func3;
            load_q  <= ~mem_wen;
            err_q   <= misalign;
            if (misalign) begin
                out_rdata <= '0;
            end else begin
                bus_addr  <= {req_addr[AW-1:2], 2'b00};
                bus_we    <= mem_wen;
                bus_wstrb <= mem_wen ? store_strb : 4'b0000;
                bus_wdata <= mem_wen ? store_data : '0;
            end
        end else if (state == REQ && bus_ack) begin
            out_rdata <= load_q ? load_data : '0;
            err_q     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ysyx_23060332_lsu.sv
// Directed bench for ysyx_23060332_lsu: vector table of single accesses plus
// hand-written reset-abort, ignored-request and back-to-back sequences.
module tb_ysyx_23060332_lsu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        mem_ren;
    logic [31:0] mem_raddr;
    logic        mem_wen;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [2:0]  ld_func3;
    logic        in_ready;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        out_valid;
    logic [31:0] out_rdata;
    logic        out_err;
    logic        lsu_busy;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic        wen;
        logic        ren;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  wmask;
        logic [2:0]  func3;
        int          ack_delay;
        logic [31:0] rdata;
        logic        skip;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        logic        exp_we;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    ysyx_23060332_lsu #(.AW(32), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .mem_ren   (mem_ren),
        .mem_raddr (mem_raddr),
        .mem_wen   (mem_wen),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .ld_func3  (ld_func3),
        .in_ready  (in_ready),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_wstrb (bus_wstrb),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata),
        .out_valid (out_valid),
        .out_rdata (out_rdata),
        .out_err   (out_err),
        .lsu_busy  (lsu_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        string p;
        p = $sformatf("v%0d", idx);
        @(negedge clk);
        checkOutput({p, "_in_ready_idle"}, {31'b0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        mem_wen   = v.wen;
        mem_ren   = v.ren;
        mem_wdata = v.wdata;
        mem_wmask = v.wmask;
        ld_func3  = v.func3;
        if (v.wen) begin
            mem_waddr = v.addr;
            mem_raddr = v.addr + 32'h40;
        end else begin
            mem_raddr = v.addr;
            mem_waddr = v.addr + 32'h40;
        end
        @(negedge clk);
        in_valid = 1'b0;
        mem_wen  = 1'b0;
        mem_ren  = 1'b0;
        if (!v.skip) begin
            for (int c = 0; c <= v.ack_delay; c++) begin
                checkOutput({p, "_bus_req"},   {31'b0, bus_req},   32'd1);
                checkOutput({p, "_in_ready"},  {31'b0, in_ready},  32'd0);
                checkOutput({p, "_busy_req"},  {31'b0, lsu_busy},  32'd1);
                checkOutput({p, "_bus_addr"},  bus_addr,           v.exp_addr);
                checkOutput({p, "_bus_we"},    {31'b0, bus_we},    {31'b0, v.exp_we});
                checkOutput({p, "_bus_wstrb"}, {28'b0, bus_wstrb}, {28'b0, v.exp_wstrb});
                if (v.exp_we)
                    checkOutput({p, "_bus_wdata"}, bus_wdata, v.exp_wdata);
                if (c == v.ack_delay) begin
                    bus_ack   = 1'b1;
                    bus_rdata = v.rdata;
                end
                @(negedge clk);
            end
            bus_ack   = 1'b0;
            bus_rdata = 32'h0BAD0BAD;
        end
        checkOutput({p, "_out_valid"}, {31'b0, out_valid}, 32'd1);
        checkOutput({p, "_req_done"},  {31'b0, bus_req},   32'd0);
        checkOutput({p, "_busy_done"}, {31'b0, lsu_busy},  32'd1);
        checkOutput({p, "_out_rdata"}, out_rdata,          v.exp_rdata);
        checkOutput({p, "_out_err"},   {31'b0, out_err},   {31'b0, v.exp_err});
        @(negedge clk);
        checkOutput({p, "_valid_pulse"}, {31'b0, out_valid}, 32'd0);
        checkOutput({p, "_ready_after"}, {31'b0, in_ready},  32'd1);
        checkOutput({p, "_rdata_hold"},  out_rdata,          v.exp_rdata);
    endtask

    initial begin
        // wen ren addr wdata wmask func3 delay rdata skip | exp_addr exp_wdata exp_wstrb exp_we exp_rdata exp_err
        vecs[0]  = '{1'b0, 1'b1, 32'h80000002, 32'h0, 8'h00, 3'b000, 0, 32'h00F00000, 1'b0,
                     32'h80000000, 32'h0, 4'b0000, 1'b0, 32'hFFFFFFF0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h80000004, 32'h12345678, 8'h0F, 3'b010, 2, 32'hFFFFFFFF, 1'b0,
                     32'h80000004, 32'h12345678, 4'b1111, 1'b1, 32'h00000000, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h80000003, 32'h000000AB, 8'h01, 3'b000, 0, 32'h0, 1'b0,
                     32'h80000000, 32'hAB000000, 4'b1000, 1'b1, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'h80000002, 32'h0, 8'h00, 3'b100, 0, 32'h00F00000, 1'b0,
                     32'h80000000, 32'h0, 4'b0000, 1'b0, 32'h000000F0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 32'h80000002, 32'h0, 8'h00, 3'b001, 0, 32'h80010000, 1'b0,
                     32'h80000000, 32'h0, 4'b0000, 1'b0, 32'hFFFF8001, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 32'h80000002, 32'h0, 8'h00, 3'b101, 0, 32'h80010000, 1'b0,
                     32'h80000000, 32'h0, 4'b0000, 1'b0, 32'h00008001, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'h80000008, 32'h0, 8'h00, 3'b010, 1, 32'hDEADBEEF, 1'b0,
                     32'h80000008, 32'h0, 4'b0000, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h80000002, 32'h0000BEEF, 8'h03, 3'b000, 0, 32'h0, 1'b0,
                     32'h80000000, 32'hBEEF0000, 4'b1100, 1'b1, 32'h00000000, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'h8000000C, 32'h0, 8'h00, 3'b011, 0, 32'hCAFEF00D, 1'b0,
                     32'h8000000C, 32'h0, 4'b0000, 1'b0, 32'hCAFEF00D, 1'b0};
`ifdef YSYX_23060332_LSU_MISALIGN_CHK_EN
        vecs[9]  = '{1'b0, 1'b1, 32'h80000001, 32'h0, 8'h00, 3'b010, 0, 32'h11223344, 1'b1,
                     32'h0, 32'h0, 4'b0000, 1'b0, 32'h00000000, 1'b1};
`else
        vecs[9]  = '{1'b0, 1'b1, 32'h80000001, 32'h0, 8'h00, 3'b010, 0, 32'h11223344, 1'b0,
                     32'h80000000, 32'h0, 4'b0000, 1'b0, 32'h00112233, 1'b0};
`endif
        vecs[10] = '{1'b1, 1'b1, 32'h80000010, 32'h00000055, 8'h01, 3'b010, 0, 32'h77777777, 1'b0,
                     32'h80000010, 32'h00000055, 4'b0001, 1'b1, 32'h00000000, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 32'h80000001, 32'h0, 8'h00, 3'b000, 0, 32'h00007F00, 1'b0,
                     32'h80000000, 32'h0, 4'b0000, 1'b0, 32'h0000007F, 1'b0};

        rst = 1'b1; in_valid = 1'b0; mem_ren = 1'b0; mem_wen = 1'b0;
        mem_raddr = '0; mem_waddr = '0; mem_wdata = '0; mem_wmask = '0; ld_func3 = '0;
        bus_ack = 1'b0; bus_rdata = '0;

        repeat (2) @(negedge clk);
        checkOutput("rst_bus_req",   {31'b0, bus_req},   32'd0);
        checkOutput("rst_bus_we",    {31'b0, bus_we},    32'd0);
        checkOutput("rst_bus_addr",  bus_addr,           32'd0);
        checkOutput("rst_bus_wdata", bus_wdata,          32'd0);
        checkOutput("rst_bus_wstrb", {28'b0, bus_wstrb}, 32'd0);
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_out_rdata", out_rdata,          32'd0);
        checkOutput("rst_out_err",   {31'b0, out_err},   32'd0);
        checkOutput("rst_lsu_busy",  {31'b0, lsu_busy},  32'd0);
        checkOutput("rst_in_ready",  {31'b0, in_ready},  32'd1);
        rst = 1'b0;

        // in_valid without any enable is ignored; a stray ack in IDLE as well
        @(negedge clk);
        in_valid = 1'b1;
        bus_ack  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        bus_ack  = 1'b0;
        checkOutput("noen_bus_req",   {31'b0, bus_req},   32'd0);
        checkOutput("noen_in_ready",  {31'b0, in_ready},  32'd1);
        checkOutput("noen_out_valid", {31'b0, out_valid}, 32'd0);

        for (int i = 0; i < 12; i++)
            applyStimulus(vecs[i], i);

        // Reset while the bus access is waiting for ack, then a late ack
        @(negedge clk);
        in_valid = 1'b1; mem_ren = 1'b1; mem_raddr = 32'h80000020; ld_func3 = 3'b010;
        @(negedge clk);
        in_valid = 1'b0; mem_ren = 1'b0;
        checkOutput("abort_req_before", {31'b0, bus_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_req_dropped", {31'b0, bus_req},  32'd0);
        checkOutput("abort_in_ready",    {31'b0, in_ready}, 32'd1);
        checkOutput("abort_busy",        {31'b0, lsu_busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'h55AA55AA;
        @(negedge clk);
        bus_ack = 1'b0;
        checkOutput("late_ack_valid",    {31'b0, out_valid}, 32'd0);
        checkOutput("late_ack_req",      {31'b0, bus_req},   32'd0);
        checkOutput("late_ack_in_ready", {31'b0, in_ready},  32'd1);
        @(negedge clk);
        checkOutput("late_ack_valid2",   {31'b0, out_valid}, 32'd0);
        checkOutput("late_ack_rdata",    out_rdata,          32'd0);

        // in_valid held high: second request accepted only the cycle after DONE
        @(negedge clk);
        in_valid = 1'b1; mem_ren = 1'b1; mem_raddr = 32'h80000030; ld_func3 = 3'b010;
        @(negedge clk);
        checkOutput("b2b_req1", {31'b0, bus_req}, 32'd1);
        bus_ack = 1'b1; bus_rdata = 32'h01020304;
        @(negedge clk);
        bus_ack = 1'b0;
        checkOutput("b2b_valid1",    {31'b0, out_valid}, 32'd1);
        checkOutput("b2b_ready_done",{31'b0, in_ready},  32'd0);
        checkOutput("b2b_rdata1",    out_rdata,          32'h01020304);
        @(negedge clk);
        checkOutput("b2b_ready_idle",{31'b0, in_ready},  32'd1);
        checkOutput("b2b_req_idle",  {31'b0, bus_req},   32'd0);
        @(negedge clk);
        in_valid = 1'b0; mem_ren = 1'b0;
        checkOutput("b2b_req2", {31'b0, bus_req}, 32'd1);
        bus_ack = 1'b1; bus_rdata = 32'h0A0B0C0D;
        @(negedge clk);
        bus_ack = 1'b0;
        checkOutput("b2b_valid2", {31'b0, out_valid}, 32'd1);
        checkOutput("b2b_rdata2", out_rdata,          32'h0A0B0C0D);
        @(negedge clk);
        checkOutput("b2b_idle_end", {31'b0, in_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/ysyx_23060332_lsu.md
YSYX_23060332_LSU -- requirements
Module: ysyx_23060332_lsu

Interface
REQ-001 SHALL have parameter AW, default 32, meaning address width.
REQ-002 SHALL have parameter DW, default 32, meaning data width; only 32 is supported.
REQ-003 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports from the execute stage: in_valid in 1, mem_ren in 1, mem_raddr in AW, mem_wen in 1, mem_waddr in AW, mem_wdata in DW, mem_wmask in 8 (bit0=byte, [1:0]=half, [3:0]=word), ld_func3 in 3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU).
REQ-006 SHALL have port: in_ready  out  1  request accepted this cycle when in_valid&in_ready.
REQ-007 SHALL have bus ports: bus_req out 1, bus_we out 1, bus_addr out AW (word aligned), bus_wdata out DW, bus_wstrb out 4, bus_ack in 1, bus_rdata in DW.
REQ-008 SHALL have writeback ports: out_valid out 1 (one-cycle pulse), out_rdata out DW, out_err out 1, lsu_busy out 1 (stall to PC/IFU).

Function
REQ-009 SHALL implement FSM states IDLE, REQ, DONE.
REQ-010 IDLE: in_ready=1; if in_valid&(mem_ren|mem_wen) SHALL latch operands and go to REQ; in_valid with neither enable SHALL be ignored.
REQ-011 If mem_wen and mem_ren both set, SHALL perform the write only; read is dropped.
REQ-012 REQ: bus_req=1 held with stable bus_addr/bus_we/bus_wdata/bus_wstrb until bus_ack sampled high; on ack SHALL go to DONE.
REQ-013 bus_ack arriving outside REQ SHALL be ignored.
REQ-014 DONE: out_valid=1 for exactly one cycle, then IDLE unconditionally.
REQ-015 in_ready SHALL be 1 only in IDLE; lsu_busy SHALL be 1 in REQ and DONE.
REQ-016 Minimum latency: accept at cycle T, bus_req at T+1, ack at T+1 gives out_valid at T+2; each ack wait cycle adds one.
REQ-017 bus_addr SHALL be {addr[AW-1:2],2'b00}; off=addr[1:0].
REQ-018 Store: bus_wstrb = mem_wmask[3:0] << off, truncated to 4 bits; bus_wdata = mem_wdata << (8*off); bus_we=1.
REQ-019 Load: bus_we=0, bus_wstrb=0; captured word shifted right 8*off, then LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged; unknown func3 treated as LW.
REQ-020 out_rdata SHALL hold the formatted load value from DONE until next DONE; for stores out_rdata SHALL be 0.
REQ-021 Back-to-back: new request SHALL be accepted earliest the cycle after DONE.

Reset
REQ-022 rst SHALL force IDLE immediately, asynchronously, aborting any in-flight access; bus_req drops without waiting for ack.
REQ-023 Reset values: bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_wstrb=0, out_valid=0, out_rdata=0, out_err=0, lsu_busy=0, in_ready=1.
REQ-024 A late bus_ack for an aborted access SHALL be ignored.

Configuration
REQ-025 Macro YSYX_23060332_LSU_MISALIGN_CHK_EN SHALL enable alignment checking.
REQ-026 With macro defined: word access with off!=0 or half access with off[0]=1 SHALL skip REQ (no bus_req), go IDLE->DONE, out_err=1, out_rdata=0; no memory modified.
REQ-027 Without macro: out_err tied 0; misaligned accesses proceed per REQ-018/019 with bytes beyond the word dropped.

Verification
REQ-028 SW addr 0x80000004 data 0x12345678 mask 0x0F, ack after 2 cycles -> bus_addr 0x80000004, wstrb 4'b1111, bus_req 3 cycles, out_valid one cycle later, out_rdata 0.
REQ-029 SB addr 0x80000003 data 0x000000AB -> wstrb 4'b1000, bus_wdata 0xAB000000.
REQ-030 LB addr 0x80000002, bus_rdata 0x00F00000, ack immediate -> out_rdata 0xFFFFFFF0 at T+2; same with LBU -> 0x000000F0.
REQ-031 LH addr 0x80000002, bus_rdata 0x8001_0000 -> out_rdata 0xFFFF8001; LHU -> 0x00008001.
REQ-032 Assert rst during REQ with ack withheld, then ack -> bus_req 0 immediately, no out_valid, in_ready 1.
REQ-033 LW addr 0x80000001: macro defined -> no bus_req, out_valid+out_err next cycle; undefined -> bus access at 0x80000000, out_err 0.
